// File: rtl/nonce_scanner.sv
// nonce_scanner
// Sweeps the 32-bit nonce field of one block header across a programmed range.
// Each candidate header goes to the downstream double-SHA-256 core. The digest
// that comes back is read as a little-endian 256-bit number and compared with
// the target. The first winning nonce is reported, or the range is flagged as
// exhausted. Every output comes straight from a flop.
module nonce_scanner (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [639:0] header_in,
  input  logic [31:0]  nonce_first,
  input  logic [31:0]  nonce_last,
  input  logic [255:0] target,
  input  logic         abort,
  output logic [639:0] hash_header,
  output logic         hash_start,
  input  logic         hash_done,
  input  logic [255:0] hash_digest,
  output logic         busy,
  output logic         found,
  output logic         exhausted,
  output logic [31:0]  found_nonce,
  output logic [31:0]  cur_nonce
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]   state_q,       state_d;
  logic [607:0] hdr_q,         hdr_d;
  logic [31:0]  nonce_last_q,  nonce_last_d;
  logic [255:0] target_q,      target_d;
  logic [255:0] digest_q,      digest_d;
  logic [31:0]  cur_nonce_q,   cur_nonce_d;
  logic [31:0]  found_nonce_q, found_nonce_d;
  logic         found_q,       found_d;
  logic         exhausted_q,   exhausted_d;
  logic         busy_q,        busy_d;
  logic         hash_start_q,  hash_start_d;
  logic [639:0] hash_header_q, hash_header_d;

  logic [255:0] check_value;
  logic         hit;
  logic [31:0]  next_nonce;
  logic         unused_nonce_field;

  // The incoming nonce field is always replaced, so its bits go nowhere.
  assign unused_nonce_field = ^header_in[31:0];

  // The nonce sits in the header little-endian, so its bytes are swapped.
  function automatic logic [31:0] byte_swap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Byte-reverse the held digest to get the numeric value compared with the target.
  always_comb begin
    check_value = '0;
    for (int i = 0; i < 32; i++) begin
      check_value[8*i +: 8] = digest_q[255-8*i -: 8];
    end
  end

  assign hit        = (check_value <= target_q);
  assign next_nonce = cur_nonce_q + 32'd1;

  // Sweep control: decide next state, next nonce and the registered outputs.
  always_comb begin
    state_d       = state_q;
    hdr_d         = hdr_q;
    nonce_last_d  = nonce_last_q;
    target_d      = target_q;
    digest_d      = digest_q;
    cur_nonce_d   = cur_nonce_q;
    found_nonce_d = found_nonce_q;
    found_d       = found_q;
    exhausted_d   = exhausted_q;
    busy_d        = busy_q;
    hash_start_d  = 1'b0;
    hash_header_d = hash_header_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // found/exhausted/found_nonce hold here until a new sweep is accepted.
        if (start) begin
          hdr_d         = header_in[639:32];
          nonce_last_d  = nonce_last;
          target_d      = target;
          found_d       = 1'b0;
          exhausted_d   = 1'b0;
          cur_nonce_d   = nonce_first;
          hash_header_d = {header_in[639:32], byte_swap32(nonce_first)};
          hash_start_d  = 1'b1;
          busy_d        = 1'b1;
          state_d       = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // hash_start was raised on the edge entering this state, so it lasts one cycle.
        if (abort) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // abort wins over a hash_done in the same cycle.
        if (abort) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (hash_done) begin
          digest_d = hash_digest;
          state_d  = ST_CHECK;
        end
      end

      ST_CHECK: begin
        // The last-nonce test is an equality, so a wrapped range (last < first)
        // simply rolls through 0xFFFFFFFF -> 0 until it meets nonce_last.
        if (abort) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (hit) begin
          found_d       = 1'b1;
          found_nonce_d = cur_nonce_q;
          busy_d        = 1'b0;
          state_d       = ST_DONE;
        end else if (cur_nonce_q == nonce_last_q) begin
          exhausted_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_DONE;
        end else begin
          cur_nonce_d   = next_nonce;
          hash_header_d = {hdr_q, byte_swap32(next_nonce)};
          hash_start_d  = 1'b1;
          state_d       = ST_ISSUE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      hdr_q         <= '0;
      nonce_last_q  <= '0;
      target_q      <= '0;
      digest_q      <= '0;
      cur_nonce_q   <= '0;
      found_nonce_q <= '0;
      found_q       <= 1'b0;
      exhausted_q   <= 1'b0;
      busy_q        <= 1'b0;
      hash_start_q  <= 1'b0;
      hash_header_q <= '0;
    end else begin
      state_q       <= state_d;
      hdr_q         <= hdr_d;
      nonce_last_q  <= nonce_last_d;
      target_q      <= target_d;
      digest_q      <= digest_d;
      cur_nonce_q   <= cur_nonce_d;
      found_nonce_q <= found_nonce_d;
      found_q       <= found_d;
      exhausted_q   <= exhausted_d;
      busy_q        <= busy_d;
      hash_start_q  <= hash_start_d;
      hash_header_q <= hash_header_d;
    end
  end

  assign hash_header = hash_header_q;
  assign hash_start  = hash_start_q;
  assign busy        = busy_q;
  assign found       = found_q;
  assign exhausted   = exhausted_q;
  assign found_nonce = found_nonce_q;
  assign cur_nonce   = cur_nonce_q;

endmodule

// File: tb/tb_nonce_scanner.sv
// tb_nonce_scanner
// Directed bench for nonce_scanner. A behavioural stand-in for the hash core
// answers each hash_start after a programmable latency, using one of several
// response modes.
module tb_nonce_scanner;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [639:0] header_in;
  logic [31:0]  nonce_first;
  logic [31:0]  nonce_last;
  logic [255:0] target;
  logic         abort;
  logic [639:0] hash_header;
  logic         hash_start;
  logic         hash_done;
  logic [255:0] hash_digest;
  logic         busy;
  logic         found;
  logic         exhausted;
  logic [31:0]  found_nonce;
  logic [31:0]  cur_nonce;

  // Hash core stand-in controls and logs
  logic         stubDone;
  logic         manualDone;
  logic [255:0] stubDigestOut;
  logic         stubEnable;
  int           stubLatency;
  int           stubMode;
  logic [31:0]  hitNonce;
  logic [255:0] stubFixed;
  int           startCount;
  logic [31:0]  nonceLog[$];
  logic [31:0]  hdrLoLog[$];

  int checkCount = 0;
  int errorCount = 0;

  localparam logic [639:0] GENESIS_HEADER =
    640'h01000000_0000000000000000000000000000000000000000000000000000000000000000_3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a_29ab5f49_ffff001d_1dac2b7c;
  localparam logic [255:0] GENESIS_VALUE =
    256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
  localparam logic [255:0] GENESIS_TARGET =
    256'h00000000ffff0000000000000000000000000000000000000000000000000000;
  localparam logic [255:0] EDGE_TARGET =
    256'h000000000000ffff00000000000000000000000000000000000000000012345678;

  assign hash_done   = stubDone | manualDone;
  assign hash_digest = stubDigestOut;

  always #5 clk = ~clk;

  nonce_scanner dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .header_in   (header_in),
    .nonce_first (nonce_first),
    .nonce_last  (nonce_last),
    .target      (target),
    .abort       (abort),
    .hash_header (hash_header),
    .hash_start  (hash_start),
    .hash_done   (hash_done),
    .hash_digest (hash_digest),
    .busy        (busy),
    .found       (found),
    .exhausted   (exhausted),
    .found_nonce (found_nonce),
    .cur_nonce   (cur_nonce)
  );

  // A digest in core byte order whose numeric (byte-reversed) value is v.
  function automatic logic [255:0] byteRev256(input logic [255:0] v);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = v[255-8*i -: 8];
    return r;
  endfunction

  function automatic logic [255:0] stubResponse(input logic [639:0] hdr);
    logic [31:0] n;
    n = {hdr[7:0], hdr[15:8], hdr[23:16], hdr[31:24]};
    case (stubMode)
      0:       return '1;
      1:       return (n == hitNonce) ? '0 : '1;
      2:       return stubFixed;
      default: return (hdr == GENESIS_HEADER) ? byteRev256(GENESIS_VALUE) : '1;
    endcase
  endfunction

  // Hash core stand-in: logs every hash_start, answers L cycles later.
  always begin
    logic [639:0] hdrSnap;
    @(negedge clk);
    if (rst_n && hash_start) begin
      startCount++;
      nonceLog.push_back(cur_nonce);
      hdrLoLog.push_back(hash_header[31:0]);
      hdrSnap = hash_header;
      if (stubEnable) begin
        repeat (stubLatency) @(posedge clk);
        #1;
        stubDigestOut = stubResponse(hdrSnap);
        stubDone = 1'b1;
        @(posedge clk);
        #1;
        stubDone = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic clearLogs();
    startCount = 0;
    nonceLog.delete();
    hdrLoLog.delete();
  endtask

  task automatic checkResetValues(input string prefix);
    checkOutput({prefix, "_busy"},        256'(busy),        256'd0);
    checkOutput({prefix, "_found"},       256'(found),       256'd0);
    checkOutput({prefix, "_exhausted"},   256'(exhausted),   256'd0);
    checkOutput({prefix, "_hash_start"},  256'(hash_start),  256'd0);
    checkOutput({prefix, "_found_nonce"}, 256'(found_nonce), 256'd0);
    checkOutput({prefix, "_cur_nonce"},   256'(cur_nonce),   256'd0);
    checkOutput({prefix, "_hdr_zero"},    256'(hash_header == '0), 256'd1);
  endtask

  // Pulse start with the given range and count cycles until found or exhausted.
  // Called #1 after a rising edge.
  task automatic applyStimulus(input logic [31:0] first, input logic [31:0] last,
                               input logic [255:0] tgt, input int limit, output int cycles);
    nonce_first = first;
    nonce_last  = last;
    target      = tgt;
    start       = 1'b1;
    cycles      = 0;
    do begin
      @(posedge clk);
      #1;
      start = 1'b0;
      cycles++;
    end while (!found && !exhausted && cycles < limit);
    checkOutput("sweep_bounded", 256'(cycles < limit), 256'd1);
  endtask

  logic [31:0] expWrap[4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
  logic [31:0] expWrapLo[4] = '{32'hFEFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h01000000};
  logic [31:0] expMidLo[4] = '{32'h05000000, 32'h06000000, 32'h07000000, 32'h08000000};

  initial begin
    int cycles;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; manualDone = 1'b0; stubDone = 1'b0;
    header_in = '0; nonce_first = '0; nonce_last = '0; target = '0;
    stubDigestOut = '0; stubEnable = 1'b1; stubLatency = 3; stubMode = 0;
    hitNonce = '0; stubFixed = '0;
    clearLogs();

    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Genesis block: single nonce, 64-cycle core
    $display("[TB] genesis header");
    clearLogs();
    header_in = {GENESIS_HEADER[639:32], 32'hDEADBEEF};
    stubMode = 3; stubLatency = 64;
    applyStimulus(32'h7C2BAC1D, 32'h7C2BAC1D, GENESIS_TARGET, 500, cycles);
    checkOutput("gen_found",       256'(found),       256'd1);
    checkOutput("gen_exhausted",   256'(exhausted),   256'd0);
    checkOutput("gen_found_nonce", 256'(found_nonce), 256'h7C2BAC1D);
    checkOutput("gen_starts",      256'(startCount),  256'd1);
    checkOutput("gen_hdr_lo",      256'((hdrLoLog.size() > 0) ? hdrLoLog[0] : 32'h0), 256'h1DAC2B7C);
    checkOutput("gen_cycles",      256'(cycles),      256'd67);
    checkOutput("gen_busy",        256'(busy),        256'd0);

    // Hit in the middle of range 5..9
    $display("[TB] mid-range hit");
    clearLogs();
    header_in = {20{32'h12345678}};
    stubMode = 1; stubLatency = 3; hitNonce = 32'd8;
    applyStimulus(32'd5, 32'd9, 256'd1, 200, cycles);
    checkOutput("mid_cycles",      256'(cycles),      256'd21);
    checkOutput("mid_starts",      256'(startCount),  256'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("mid_nonce%0d", i),  256'((nonceLog.size() > i) ? nonceLog[i] : 32'hX), 256'(5 + i));
      checkOutput($sformatf("mid_hdr_lo%0d", i), 256'((hdrLoLog.size() > i) ? hdrLoLog[i] : 32'hX), 256'(expMidLo[i]));
    end
    checkOutput("mid_found",       256'(found),       256'd1);
    checkOutput("mid_exhausted",   256'(exhausted),   256'd0);
    checkOutput("mid_found_nonce", 256'(found_nonce), 256'd8);

    // Wrapped range, never hits
    $display("[TB] wrap and exhaust");
    clearLogs();
    stubMode = 0; stubLatency = 2;
    applyStimulus(32'hFFFFFFFE, 32'h00000001, 256'd1, 200, cycles);
    checkOutput("wrap_cycles", 256'(cycles),     256'd17);
    checkOutput("wrap_starts", 256'(startCount), 256'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("wrap_nonce%0d", i),  256'((nonceLog.size() > i) ? nonceLog[i] : 32'hX), 256'(expWrap[i]));
      checkOutput($sformatf("wrap_hdr_lo%0d", i), 256'((hdrLoLog.size() > i) ? hdrLoLog[i] : 32'hX), 256'(expWrapLo[i]));
    end
    checkOutput("wrap_exhausted", 256'(exhausted), 256'd1);
    checkOutput("wrap_found",     256'(found),     256'd0);

    // Compare boundary: value == target hits, value == target+1 does not
    $display("[TB] compare boundary");
    clearLogs();
    stubMode = 2; stubLatency = 1; stubFixed = byteRev256(EDGE_TARGET);
    applyStimulus(32'h42, 32'h42, EDGE_TARGET, 50, cycles);
    checkOutput("eq_found",       256'(found),       256'd1);
    checkOutput("eq_exhausted",   256'(exhausted),   256'd0);
    checkOutput("eq_found_nonce", 256'(found_nonce), 256'h42);
    checkOutput("eq_cycles",      256'(cycles),      256'd4);
    clearLogs();
    stubFixed = byteRev256(EDGE_TARGET + 256'd1);
    applyStimulus(32'h42, 32'h42, EDGE_TARGET, 50, cycles);
    checkOutput("gt_found",     256'(found),      256'd0);
    checkOutput("gt_exhausted", 256'(exhausted),  256'd1);
    checkOutput("gt_starts",    256'(startCount), 256'd1);

    // Abort in CHECK beats a hit in the same cycle
    $display("[TB] abort during check");
    clearLogs();
    stubMode = 1; stubLatency = 1; hitNonce = 32'h5;
    nonce_first = 32'h5; nonce_last = 32'h5; target = 256'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    checkOutput("abchk_found", 256'(found), 256'd0);
    checkOutput("abchk_busy",  256'(busy),  256'd0);
    repeat (3) @(posedge clk);
    #1;

    // Abort in WAIT, ignored start while busy, spurious done afterwards
    $display("[TB] abort and spurious done");
    clearLogs();
    stubEnable = 1'b0;
    nonce_first = 32'h100; nonce_last = 32'h1FF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    checkOutput("ab_busy_wait", 256'(busy), 256'd1);
    nonce_first = 32'h999; nonce_last = 32'h999; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    checkOutput("ab_ignored_start", 256'(cur_nonce), 256'h100);
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    checkOutput("ab_busy",      256'(busy),      256'd0);
    checkOutput("ab_found",     256'(found),     256'd0);
    checkOutput("ab_exhausted", 256'(exhausted), 256'd0);
    repeat (2) @(posedge clk);
    #1; manualDone = 1'b1;
    @(posedge clk); #1; manualDone = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("ab_starts",     256'(startCount), 256'd1);
    checkOutput("ab_busy_after", 256'(busy),       256'd0);
    checkOutput("ab_found_after", 256'(found | exhausted), 256'd0);
    stubEnable = 1'b1;

    // Asynchronous reset in WAIT, then a clean restart
    $display("[TB] reset mid-sweep");
    clearLogs();
    stubMode = 1; stubLatency = 3; hitNonce = 32'h21;
    nonce_first = 32'h20; nonce_last = 32'h30; target = 256'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_busy_before", 256'(busy), 256'd1);
    #2; rst_n = 1'b0;
    #1;
    checkResetValues("rst_mid");
    repeat (6) @(posedge clk);
    #1;
    checkOutput("rst_no_start", 256'(startCount), 256'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    clearLogs();
    applyStimulus(32'h20, 32'h30, 256'd1, 100, cycles);
    checkOutput("rst_first_nonce", 256'((nonceLog.size() > 0) ? nonceLog[0] : 32'hX), 256'h20);
    checkOutput("rst_starts",      256'(startCount),  256'd2);
    checkOutput("rst_found_nonce", 256'(found_nonce), 256'h21);
    checkOutput("rst_cycles",      256'(cycles),      256'd11);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
